// File: rtl/network_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : network_mul_share_arbiter
// Purpose  : Round-robin sharing of one external pipelined 16s x 11u
//            multiplier among NUM_REQ requesters. Operands are registered
//            into an issue stage, requester tags travel alongside the
//            multiplier pipeline, and products return on one valid/ready
//            port. Backpressure freezes the whole pipe via mul_ce.
// Revision : 1.0 - initial release
// ============================================================================
module network_mul_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TAG_W      = 2,
  parameter int MUL_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*16-1:0]   req_din0,
  input  logic [NUM_REQ*11-1:0]   req_din1,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [26:0]             res_dout,
  output logic [TAG_W-1:0]        res_tag,
  output logic                    mul_ce,
  output logic [15:0]             mul_din0,
  output logic [10:0]             mul_din1,
  input  logic [26:0]             mul_dout,
  output logic [1:0]              in_flight
);

  // Issue register plus the multiplier's internal stages.
  localparam int STAGES = 1 + MUL_STAGES;

  logic [STAGES-1:0] v;
  logic [TAG_W-1:0]  t [STAGES];
  logic [TAG_W-1:0]  ptr;

  logic              grant_found;
  logic [TAG_W-1:0]  grant_idx;
  logic              xfer;

  // The pipe only stalls when a finished product is waiting on the consumer.
  assign mul_ce = !(v[STAGES-1] && !res_ready);

  // A granted requester always has req_valid high, so grant + enable is a transfer.
  assign xfer = grant_found && mul_ce && reset;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_W'(idx);
      end
    end
  end

  // One-hot accept to the winner; nothing is accepted while in reset or stalled.
  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Issue stage, tag/valid shift register and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v        <= '0;
      ptr      <= TAG_W'(NUM_REQ - 1);
      mul_din0 <= '0;
      mul_din1 <= '0;
      for (int s = 0; s < STAGES; s++) begin
        t[s] <= '0;
      end
    end else if (mul_ce) begin
      v[0] <= xfer;
      if (xfer) begin
        t[0]     <= grant_idx;
        ptr      <= grant_idx;
        mul_din0 <= req_din0[int'(grant_idx)*16 +: 16];
        mul_din1 <= req_din1[int'(grant_idx)*11 +: 11];
      end
      for (int s = 1; s < STAGES; s++) begin
        v[s] <= v[s-1];
        t[s] <= t[s-1];
      end
    end
  end

  // Number of occupied pipeline stages.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int s = 0; s < STAGES; s++) begin
      cnt = cnt + int'(v[s]);
    end
    in_flight = 2'(cnt);
  end

  assign res_valid = v[STAGES-1];
  assign res_tag   = t[STAGES-1];
  assign res_dout  = mul_dout;

endmodule
`default_nettype wire

// File: doc/network_mul_share_arbiter.md
Name: network_mul_share_arbiter

Overview:
- Shares one 16s x 11ns multiplier instance (2 internal register stages, clock-enable driven) among NUM_REQ requesters.
- Performs round-robin arbitration and registers the granted operands into an issue stage.
- Tracks requester tags alongside the multiplier pipeline and returns each product with its tag on a single valid/ready result port.
- Applies backpressure by dropping the multiplier clock-enable. Sits between the conv/pool datapath lanes and the shared multiplier.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_W, 2, result tag width; must be >= clog2(NUM_REQ).
- MUL_STAGES, 2, register stages inside the multiplier (a/b reg, p reg).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_din0  in  NUM_REQ*16  signed operands, requester i at bits [16i+15:16i].
- req_din1  in  NUM_REQ*11  unsigned operands, requester i at bits [11i+10:11i].
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_dout  out  27  signed product.
- res_tag  out  TAG_W  index of the requester that issued the product.
- mul_ce  out  1  multiplier clock-enable.
- mul_din0  out  16  to multiplier din0.
- mul_din1  out  11  to multiplier din1.
- mul_dout  in  27  from multiplier dout.
- in_flight  out  2  count of valid pipeline stages, 0..3.

Behaviour:
Reset (reset=0, asynchronous):
- Clears all stage valid bits: res_valid=0, in_flight=0.
- Clears issue registers: mul_din0=0, mul_din1=0.
- Clears all tags to 0 and sets the RR pointer to NUM_REQ-1, so requester 0 has highest priority first.
- req_ready=0 while reset is asserted.

Stall:
- Pipeline of 1 + MUL_STAGES = 3 stages. Stage valid bits v[0..2] and tags t[0..2] shift only when mul_ce=1.
- mul_ce = !(v[2] && !res_ready), combinational. When low, the issue register, tags, valids and the multiplier all hold.

Arbitration (combinational):
- Grant goes to the first requester with req_valid=1, searching from pointer+1 with wrap-around modulo NUM_REQ.
- req_ready[g] = grant_found && mul_ce; all other bits are 0.
- A transfer occurs when req_valid[g] && req_ready[g].

Issue (on edge with mul_ce=1):
- On a transfer: v[0]<=1, t[0]<=g, mul_din0/mul_din1 <= the granted operands, pointer <= g.
- With no transfer: v[0]<=0 (bubble), operands and pointer hold.
- The pointer never moves without a transfer.

Output:
- res_valid = v[2]; res_tag = t[2]; res_dout = mul_dout, passed through.
- Latency: with mul_ce continuously high, a transfer at edge E gives res_valid=1 after edge E+2, i.e. the third cycle counting the accept cycle.
- Throughput: 1 product per cycle when res_ready=1.
- Result is consumed on res_valid && res_ready. res_valid, res_dout and res_tag stay stable while res_valid=1 and res_ready=0.

Boundary conditions:
- Pipeline full and res_ready=0: all req_ready are 0 and no state changes.
- Full pipeline with res_ready returning to 1: in the same cycle the head is consumed, a new request is accepted and the pipe shifts.
- Single active requester: it is granted every cycle, back-to-back.
- A requester dropping req_valid before its accept has no effect; req_valid needs no stickiness.
- in_flight = v[0]+v[1]+v[2].
- Reset mid-operation discards all in-flight products; no result is emitted for them.

Arithmetic:
- Product is din0 (signed 16) times zero-extended din1 (11 bits), giving 27-bit signed.
- The block never modifies the data; it only routes operands and the product.

Test Plan:
1. Reset, then req 0 only with din0=-3, din1=100, res_ready=1 -> req_ready[0]=1 in the first cycle; res_valid after 2 edges with res_dout=-300, res_tag=0; in_flight returns to 0.
2. All 4 requesters valid continuously, res_ready=1 -> grant order 0,1,2,3,0,...; res_tag sequence 0,1,2,3 back-to-back with no bubbles.
3. Issue 3 products, then hold res_ready=0 for 5 cycles -> mul_ce=0, req_ready=0, res_dout/res_tag frozen, in_flight=3. Release -> 3 results drain in order with values intact.
4. Only requesters 1 and 3 valid, pointer starting at 3 -> grants alternate 1,3,1,3; pointer does not move in idle cycles.
5. Operands din0=-32768, din1=2047 -> res_dout=-67076096; and din0=32767, din1=2047 -> 67074049.
6. Assert reset with in_flight=2 -> res_valid=0 immediately (asynchronous) and in_flight=0. After release, requester 0 is granted first and no stale result appears.
